// File: rtl/multi_channel_capture_buffer_if.sv
// Stream bundle for the capture buffer: the sample word bus coming in from the
// ADC lanes and the beat-wide valid/ready stream going out to the host.
interface multi_channel_capture_buffer_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 8
);
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] DataIn;
    logic                                 DataInValid;
    logic [SAMPLE_WIDTH-1:0]              DataOut;
    logic                                 DataOutValid;
    logic                                 DataOutReady;
    logic                                 DataOutLast;

    // Capture buffer side: takes samples in, drives the output stream.
    modport master (
        input  DataIn, DataInValid, DataOutReady,
        output DataOut, DataOutValid, DataOutLast
    );

    // Environment side: supplies samples, consumes the output stream.
    modport slave (
        output DataIn, DataInValid, DataOutReady,
        input  DataOut, DataOutValid, DataOutLast
    );
endinterface

// File: rtl/multi_channel_capture_buffer.sv
// Multi-channel capture buffer: records a programmable number of sample words
// after an armed rising trigger edge, then streams a signature header followed
// by every captured lane as a flow-controlled beat stream.
module multi_channel_capture_buffer #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH_LOG2   = 12,
    parameter int HEADER_BEATS = 4,
    parameter logic [HEADER_BEATS*SAMPLE_WIDTH-1:0] HEADER_VALUE = 32'hFF807F00
) (
    input  logic                          Clock,
    input  logic                          Reset,
    multi_channel_capture_buffer_if.master bus,
    input  logic                          Arm,
    input  logic                          Trigger,
    input  logic [DEPTH_LOG2:0]           CaptureLength,
    input  logic                          AutoRearm,
    input  logic                          Abort,
    output logic [1:0]                    State,
    output logic [DEPTH_LOG2:0]           WordsCaptured
);
    localparam int WORD_W = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int LEN_W  = DEPTH_LOG2 + 1;
    localparam int LANE_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int HDR_W  = (HEADER_BEATS > 1) ? $clog2(HEADER_BEATS) : 1;
    localparam logic [LEN_W-1:0]  MAX_LEN   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [LEN_W-1:0]  ONE_LEN   = LEN_W'(1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_CHANNELS - 1);
    localparam logic [HDR_W-1:0]  LAST_HDR  = HDR_W'(HEADER_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMED     = 2'b01,
        CAPTURING = 2'b10,
        SENDING   = 2'b11
    } captureState_e;

    captureState_e state;
    logic              triggerPrev;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  wordCount;
    logic [LEN_W-1:0]  fetchPtr;
    logic [LEN_W-1:0]  fetchPtrNext;
    logic [HDR_W-1:0]  hdrIdx;
    logic              inHeader;
    logic [LANE_W-1:0] lane;
    logic [SAMPLE_WIDTH-1:0] dataOutReg;
    logic              validReg;
    logic              lastReg;

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];
    logic [WORD_W-1:0] memData;

    logic              triggerEdge;
    logic [LEN_W-1:0]  clampedLen;
    logic              writeEn;
    logic              startSend;
    logic              loadBeat;
    logic [SAMPLE_WIDTH-1:0] laneBeat;
    logic [SAMPLE_WIDTH-1:0] headerBeat;

    assign bus.DataOut      = dataOutReg;
    assign bus.DataOutValid = validReg;
    assign bus.DataOutLast  = lastReg;
    assign State            = state;
    assign WordsCaptured    = wordCount;

    // Decode edges, memory writes, send start and the next beat to present.
    // fetchPtrNext is the word the memory should hold next cycle, so the
    // following lane is always ready without a bubble.
    always_comb begin
        triggerEdge = Trigger & ~triggerPrev;
        clampedLen  = (CaptureLength > MAX_LEN) ? MAX_LEN : CaptureLength;
        writeEn     = 1'b0;
        startSend   = 1'b0;
        if (!Abort) begin
            if (state == ARMED && triggerEdge) begin
                writeEn   = (lenReg != '0) && bus.DataInValid;
                startSend = (lenReg == '0) || (bus.DataInValid && lenReg == ONE_LEN);
            end else if (state == CAPTURING && bus.DataInValid) begin
                writeEn   = 1'b1;
                startSend = (wordCount + ONE_LEN) == lenReg;
            end
        end
        loadBeat = (state == SENDING) && !Abort &&
                   (!validReg || bus.DataOutReady) && !(validReg && lastReg);
        fetchPtrNext = '0;
        if (state == SENDING && !Abort) begin
            fetchPtrNext = fetchPtr;
            if (loadBeat && !inHeader && lane == LAST_LANE) begin
                fetchPtrNext = fetchPtr + ONE_LEN;
            end
        end
        laneBeat   = memData[int'(lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        headerBeat = HEADER_VALUE[(HEADER_BEATS-1-int'(hdrIdx))*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    // Capture memory with one-cycle read; a word written to the address being
    // fetched is forwarded so a freshly stored word 0 is never read stale.
    always_ff @(posedge Clock) begin
        if (writeEn) begin
            mem[wordCount[DEPTH_LOG2-1:0]] <= bus.DataIn;
        end
        if (writeEn && wordCount == fetchPtrNext) begin
            memData <= bus.DataIn;
        end else begin
            memData <= mem[fetchPtrNext[DEPTH_LOG2-1:0]];
        end
    end

    // Capture/send state machine with registered stream outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            triggerPrev <= 1'b0;
            lenReg      <= '0;
            wordCount   <= '0;
            fetchPtr    <= '0;
            hdrIdx      <= '0;
            inHeader    <= 1'b0;
            lane        <= '0;
            dataOutReg  <= '0;
            validReg    <= 1'b0;
            lastReg     <= 1'b0;
        end else begin
            triggerPrev <= Trigger;
            fetchPtr    <= fetchPtrNext;
            if (Abort) begin
                state    <= IDLE;
                validReg <= 1'b0;
                lastReg  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Arm) begin
                            state     <= ARMED;
                            lenReg    <= clampedLen;
                            wordCount <= '0;
                        end
                    end
                    ARMED: begin
                        if (triggerEdge) begin
                            state <= CAPTURING;
                            if (writeEn) begin
                                wordCount <= ONE_LEN;
                            end
                        end
                    end
                    CAPTURING: begin
                        if (writeEn) begin
                            wordCount <= wordCount + ONE_LEN;
                        end
                    end
                    SENDING: begin
                        if (validReg && bus.DataOutReady && lastReg) begin
                            validReg <= 1'b0;
                            lastReg  <= 1'b0;
                            if (AutoRearm) begin
                                state     <= ARMED;
                                lenReg    <= clampedLen;
                                wordCount <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (loadBeat) begin
                            validReg <= 1'b1;
                            if (inHeader) begin
                                dataOutReg <= headerBeat;
                                lastReg    <= (hdrIdx == LAST_HDR) && (lenReg == '0);
                                hdrIdx     <= hdrIdx + HDR_W'(1);
                                if (hdrIdx == LAST_HDR) begin
                                    inHeader <= 1'b0;
                                end
                            end else begin
                                dataOutReg <= laneBeat;
                                lastReg    <= (fetchPtr == lenReg - ONE_LEN) && (lane == LAST_LANE);
                                lane       <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
                            end
                        end
                    end
                endcase
                if (startSend) begin
                    state      <= SENDING;
                    dataOutReg <= HEADER_VALUE[(HEADER_BEATS-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    validReg   <= 1'b1;
                    lastReg    <= (HEADER_BEATS == 1) && (lenReg == '0);
                    hdrIdx     <= (HEADER_BEATS > 1) ? HDR_W'(1) : '0;
                    inHeader   <= (HEADER_BEATS > 1);
                    lane       <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_channel_capture_buffer.sv
// Self-checking bench for the capture buffer: drives captures with random data
// and random handshake patterns, and compares every frame against a list of
// expected beats built from the captured words.
module tb_multi_channel_capture_buffer;
    localparam int NC = 4;
    localparam int SW = 8;
    localparam int DL = 4;
    localparam int HB = 4;
    localparam int MAXW = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Arm;
    logic          Trigger;
    logic [DL:0]   CaptureLength;
    logic          AutoRearm;
    logic          Abort;
    logic [1:0]    State;
    logic [DL:0]   WordsCaptured;

    multi_channel_capture_buffer_if #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW)) bus ();

    multi_channel_capture_buffer #(
        .NUM_CHANNELS(NC),
        .SAMPLE_WIDTH(SW),
        .DEPTH_LOG2(DL),
        .HEADER_BEATS(HB),
        .HEADER_VALUE(32'hFF807F00)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus),
        .Arm(Arm),
        .Trigger(Trigger),
        .CaptureLength(CaptureLength),
        .AutoRearm(AutoRearm),
        .Abort(Abort),
        .State(State),
        .WordsCaptured(WordsCaptured)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    int checkCount = 0;
    int errorCount = 0;
    int cycleNo = 0;
    int readyMode = 0;
    int readyPhase = 0;
    logic [8:0] gotBeats[$];
    int gotCycles[$];
    bit lastSeen = 1'b0;
    bit prevStall = 1'b0;
    logic [7:0] prevData;
    logic prevLast;
    bit armedNow = 1'b0;
    int rearmLen = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: at the falling edge, check stall stability, pick Ready and
    // record a beat that will transfer on the coming rising edge.
    task automatic tick();
        @(negedge Clock);
        cycleNo++;
        if (prevStall) begin
            checkOutput("stall_valid", 32'(bus.DataOutValid), 32'd1);
            checkOutput("stall_data", 32'(bus.DataOut), 32'(prevData));
            checkOutput("stall_last", 32'(bus.DataOutLast), 32'(prevLast));
        end
        case (readyMode)
            0: bus.DataOutReady = 1'b1;
            1: begin
                bus.DataOutReady = (readyPhase % 4 == 0) || (readyPhase % 4 == 3);
                readyPhase++;
            end
            default: bus.DataOutReady = 1'($urandom_range(1, 0));
        endcase
        if (bus.DataOutValid && bus.DataOutReady) begin
            gotBeats.push_back({bus.DataOutLast, bus.DataOut});
            gotCycles.push_back(cycleNo);
            if (bus.DataOutLast) lastSeen = 1'b1;
        end
        prevStall = bus.DataOutValid && !bus.DataOutReady;
        prevData  = bus.DataOut;
        prevLast  = bus.DataOutLast;
    endtask

    task automatic applyStimulus(input int len, input int pct, input int rmode, input bit autoRe,
                                 input bit doArm, input bit fixedData, input int abortAt);
        logic [31:0] words[$];
        logic [7:0]  expBeats[$];
        logic [31:0] hdr = 32'hFF807F00;
        logic [31:0] w;
        int effLen;
        int budget;
        int n;
        bit v;
        effLen = doArm ? ((len > MAXW) ? MAXW : len) : rearmLen;
        gotBeats.delete();
        gotCycles.delete();
        lastSeen = 1'b0;
        readyMode = rmode;
        readyPhase = 0;
        CaptureLength = 5'(len);
        AutoRearm = autoRe;
        if (doArm) begin
            Arm = 1'b1;
            tick();
            Arm = 1'b0;
            checkOutput("armed_state", 32'(State), 32'd1);
        end
        Trigger = 1'b0;
        bus.DataInValid = 1'b0;
        tick();
        Trigger = 1'b1;
        budget = 300;
        do begin
            v = (pct >= 100) || ($urandom_range(99, 0) < pct);
            w = fixedData ? 32'h03020100 + 32'(words.size()) * 32'h04040404 : $urandom;
            bus.DataInValid = v;
            bus.DataIn = w;
            if (v && words.size() < effLen) words.push_back(w);
            tick();
            budget--;
        end while (words.size() < effLen && budget > 0);
        bus.DataInValid = 1'b0;
        Trigger = 1'b0;
        for (int i = 0; i < HB; i++) expBeats.push_back(hdr[31-8*i -: 8]);
        foreach (words[k]) for (int l = 0; l < NC; l++) expBeats.push_back(words[k][l*8 +: 8]);
        budget = 800;
        while (!lastSeen && budget > 0) begin
            if (abortAt > 0 && gotBeats.size() >= abortAt) break;
            tick();
            budget--;
        end
        if (abortAt > 0) begin
            Abort = 1'b1;
            tick();
            Abort = 1'b0;
            checkOutput("abort_valid", 32'(bus.DataOutValid), 32'd0);
            checkOutput("abort_last", 32'(bus.DataOutLast), 32'd0);
            checkOutput("abort_state", 32'(State), 32'd0);
            checkOutput("abort_words", 32'(WordsCaptured), 32'(effLen));
            checkOutput("abort_beats", 32'(gotBeats.size()), 32'(abortAt));
            foreach (gotBeats[i]) begin
                checkOutput($sformatf("abort_data[%0d]", i), 32'(gotBeats[i][7:0]), 32'(expBeats[i]));
                checkOutput($sformatf("abort_lastflag[%0d]", i), 32'(gotBeats[i][8]), 32'd0);
            end
            armedNow = 1'b0;
            return;
        end
        if (!lastSeen) checkOutput("frame_timeout", 32'd0, 32'd1);
        tick();
        checkOutput("end_valid", 32'(bus.DataOutValid), 32'd0);
        checkOutput("end_state", 32'(State), autoRe ? 32'd1 : 32'd0);
        checkOutput("end_words", 32'(WordsCaptured), autoRe ? 32'd0 : 32'(effLen));
        checkOutput("frame_len", 32'(gotBeats.size()), 32'(expBeats.size()));
        n = (gotBeats.size() < expBeats.size()) ? gotBeats.size() : expBeats.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("beat_data[%0d]", i), 32'(gotBeats[i][7:0]), 32'(expBeats[i]));
            checkOutput($sformatf("beat_last[%0d]", i), 32'(gotBeats[i][8]), 32'(i == expBeats.size() - 1));
            if (rmode == 0) checkOutput($sformatf("beat_gap[%0d]", i), 32'(gotCycles[i] - gotCycles[0]), 32'(i));
        end
        armedNow = autoRe;
        if (autoRe) rearmLen = (len > MAXW) ? MAXW : len;
    endtask

    initial begin
        Reset = 1'b1;
        Arm = 1'b0;
        Trigger = 1'b0;
        CaptureLength = '0;
        AutoRearm = 1'b0;
        Abort = 1'b0;
        bus.DataIn = '0;
        bus.DataInValid = 1'b0;
        bus.DataOutReady = 1'b1;
        repeat (3) tick();
        checkOutput("reset_state", 32'(State), 32'd0);
        checkOutput("reset_valid", 32'(bus.DataOutValid), 32'd0);
        checkOutput("reset_last", 32'(bus.DataOutLast), 32'd0);
        checkOutput("reset_data", 32'(bus.DataOut), 32'd0);
        checkOutput("reset_words", 32'(WordsCaptured), 32'd0);
        Reset = 1'b0;
        tick();

        $display("[TB] basic frame");
        applyStimulus(3, 100, 0, 1'b0, 1'b1, 1'b1, 0);
        $display("[TB] backpressure");
        applyStimulus(3, 100, 1, 1'b0, 1'b1, 1'b1, 0);
        $display("[TB] clamp with gaps");
        applyStimulus(20, 50, 2, 1'b0, 1'b1, 1'b0, 0);
        $display("[TB] zero length with rearm");
        applyStimulus(0, 100, 0, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(0, 100, 2, 1'b0, 1'b0, 1'b0, 0);
        $display("[TB] abort mid-send");
        applyStimulus(3, 100, 0, 1'b0, 1'b1, 1'b1, 7);
        applyStimulus(5, 100, 2, 1'b0, 1'b1, 1'b0, 0);

        $display("[TB] random frames");
        for (int it = 0; it < 6; it++) begin
            applyStimulus(int'($urandom_range(18, 0)), int'($urandom_range(100, 30)),
                          int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
                          !armedNow, 1'b0, 0);
        end
        if (armedNow) begin
            Abort = 1'b1;
            tick();
            Abort = 1'b0;
            checkOutput("disarm_state", 32'(State), 32'd0);
            armedNow = 1'b0;
        end

        $display("[TB] reset mid-capture");
        readyMode = 0;
        CaptureLength = 5'd5;
        AutoRearm = 1'b0;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        Trigger = 1'b0;
        tick();
        Trigger = 1'b1;
        bus.DataInValid = 1'b1;
        bus.DataIn = $urandom;
        tick();
        bus.DataIn = $urandom;
        tick();
        checkOutput("cap_state", 32'(State), 32'd2);
        checkOutput("cap_words", 32'(WordsCaptured), 32'd2);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async_state", 32'(State), 32'd0);
        checkOutput("async_valid", 32'(bus.DataOutValid), 32'd0);
        checkOutput("async_last", 32'(bus.DataOutLast), 32'd0);
        checkOutput("async_data", 32'(bus.DataOut), 32'd0);
        checkOutput("async_words", 32'(WordsCaptured), 32'd0);
        tick();
        Reset = 1'b0;
        bus.DataInValid = 1'b0;
        Trigger = 1'b0;
        tick();
        Trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_idle", 32'(State), 32'd0);
        end
        Trigger = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/multi_channel_capture_buffer.md
Name: multi_channel_capture_buffer

Overview:
Parametrised, single-clock successor to the four-lane ADC capture store. It records N channels of SAMPLE_WIDTH-bit samples after an armed rising-edge trigger, for a programmable length. It then serialises a signature header, followed by the samples, as a sample-wide valid/ready stream toward the host transmit path. It adds programmable capture length, auto-rearm, abort, frame-last marking and flow-controlled output, none of which the fixed 4x8-bit store provides.

Parameters:
NUM_CHANNELS, 4, number of sample lanes packed into DataIn (≥1)
SAMPLE_WIDTH, 8, bits per lane sample and per output beat
DEPTH_LOG2, 12, capture memory holds 2**DEPTH_LOG2 words of NUM_CHANNELS*SAMPLE_WIDTH
HEADER_BEATS, 4, number of signature beats sent before samples (≥1)
HEADER_VALUE, 32'hFF807F00, signature of HEADER_BEATS*SAMPLE_WIDTH bits; most-significant beat is sent first

Ports:
Clock  in  1  single clock for all logic
Reset  in  1  asynchronous, active-high reset
DataIn  in  NUM_CHANNELS*SAMPLE_WIDTH  lane k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
DataInValid  in  1  DataIn holds a new sample word this cycle
Arm  in  1  level; arms capture when the block is IDLE
Trigger  in  1  capture starts on its rising edge while ARMED
CaptureLength  in  DEPTH_LOG2+1  number of sample words to capture; latched on leaving IDLE
AutoRearm  in  1  on end of frame: 1 returns to ARMED, 0 returns to IDLE
Abort  in  1  forces IDLE from any state
DataOut  out  SAMPLE_WIDTH  output beat
DataOutValid  out  1  DataOut is valid
DataOutReady  in  1  consumer accepts the beat when high together with DataOutValid
DataOutLast  out  1  marks the final beat of a frame
State  out  2  IDLE=00, ARMED=01, CAPTURING=10, SENDING=11
WordsCaptured  out  DEPTH_LOG2+1  count of words written in the current or last capture

Behaviour:
- Reset (async assert, sync release): State=IDLE, DataOutValid=0, DataOutLast=0, DataOut=0, WordsCaptured=0, trigger edge register=0.
- Trigger edge register: prev <= Trigger on every cycle. An edge is defined as Trigger=1 & prev=0.
- IDLE:
  - Arm=1 -> ARMED on the next cycle.
  - Latch len = min(CaptureLength, 2**DEPTH_LOG2) and clear WordsCaptured.
- ARMED:
  - An edge without DataInValid -> CAPTURING; no write that cycle.
  - An edge with DataInValid -> that same DataIn word is written as word 0, then CAPTURING.
  - If len=0, an edge -> SENDING directly; the frame is header only.
- CAPTURING:
  - Each DataInValid cycle writes DataIn at address WordsCaptured and increments WordsCaptured.
  - When the write that makes WordsCaptured==len occurs -> SENDING on the next cycle.
  - Trigger edges are ignored while CAPTURING.
- SENDING:
  - Emit HEADER_BEATS beats, then for each word 0..len-1 emit lanes 0..NUM_CHANNELS-1 in order (lane 0 first).
  - Frame length = HEADER_BEATS + len*NUM_CHANNELS beats.
  - The first header beat is valid on the first SENDING cycle.
- Handshake:
  - A beat transfers on DataOutValid & DataOutReady.
  - While Valid=1 and Ready=0, DataOut and DataOutLast hold stable.
  - DataOutValid never deasserts without a transfer, except on Abort or Reset.
- Throughput: with DataOutReady held high, one beat per cycle with no bubbles, including the header-to-sample boundary. Memory read latency is one cycle; the implementation prefetches.
- DataOutLast=1 only on the final beat.
- End of frame: on the cycle the last beat transfers, DataOutValid drops next cycle and State -> ARMED if AutoRearm=1, else IDLE.
  - On rearm, len is re-latched from CaptureLength and WordsCaptured is cleared.
  - A trigger edge must not be recognised on that rearm cycle itself; prev keeps updating throughout.
- Abort:
  - Highest priority; in any state -> IDLE next cycle with DataOutValid=0 and DataOutLast=0.
  - A partial frame is not completed; the consumer sees a truncated frame with no Last.
  - WordsCaptured holds its value.
- Arm in a non-IDLE state is ignored. Arm and Abort together -> Abort wins.
- Memory contents are not cleared by reset; only captured addresses are ever read.

Test Plan:
- Bench parameters: NUM_CHANNELS=4, SAMPLE_WIDTH=8, DEPTH_LOG2=4, HEADER_VALUE=32'hFF807F00.
- Basic frame: CaptureLength=3, Arm, then a Trigger edge with DataIn=32'h03020100, 32'h07060504, 32'h0B0A0908 on consecutive valid cycles, Ready=1.
  -> Beats FF,80,7F,00,00,01,02,03,04,...,0B on 16 consecutive cycles; Last on 0B; State returns to 00.
- Backpressure: same frame, Ready toggling 1,0,0,1 repeatedly.
  -> Identical 16-beat sequence; DataOut is stable during every stall; no beat is dropped or duplicated.
- Clamp and gaps: CaptureLength=20 with DataInValid 50% duty.
  -> WordsCaptured stops at 16; only valid words are stored; frame is 4+64 beats.
- Zero length plus AutoRearm: CaptureLength=0, AutoRearm=1, Trigger edge.
  -> Frame is 4 header beats with Last on 00; State 11 -> 01; a second edge produces a second header-only frame.
- Abort mid-send: Abort asserted on beat 7 while Ready=1.
  -> DataOutValid=0 next cycle, State=00, no Last; a following Arm+Trigger produces a complete new frame.
- Reset mid-capture: assert Reset asynchronously during CAPTURING.
  -> All outputs reach their reset values immediately; after release, State=00 and Trigger is ignored until Arm.
